// File: rtl/quad_updown_decoder.sv
// quad_updown_decoder: quadrature decoder producing step/direction events, a wrapping position count and a saturating illegal-transition count
module quad_updown_decoder #(
    parameter int WIDTH     = 4,
    parameter int ERR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 quad_a,
    input  logic                 quad_b,
    output logic [WIDTH-1:0]     count,
    output logic                 up_down,
    output logic                 step,
    output logic                 wrap,
    output logic                 err,
    output logic [ERR_WIDTH-1:0] err_count
);
    typedef enum logic [1:0] {PRIME0, PRIME1, RUN} state_t;

    state_t     state, state_next;
    logic       a_s1, a_s2, b_s1, b_s2;
    logic [1:0] prev, cur, delta;
    logic       fwd, rev, bad;

    // Phase position along the up cycle 00,10,11,01 is {b, a^b}; the
    // modulo-4 difference of positions is 1 for up, 3 for down, 2 for a double jump.
    assign cur   = {a_s2, b_s2};
    assign delta = {cur[0], ^cur} - {prev[0], ^prev};
    assign fwd   = (state == RUN) && (delta == 2'd1);
    assign rev   = (state == RUN) && (delta == 2'd3);
    assign bad   = (state == RUN) && (delta == 2'd2);

    // Two-flop synchronisers for the asynchronous phase inputs
    always_ff @(posedge clk) begin
        if (reset) {a_s1, a_s2, b_s1, b_s2} <= '0;
        else       {a_s1, a_s2, b_s1, b_s2} <= {quad_a, a_s1, quad_b, b_s1};
    end

    // State register
    always_ff @(posedge clk) begin
        state <= reset ? PRIME0 : state_next;
    end

    // Two priming cycles, then run forever
    always_comb begin
        state_next = (state == PRIME0) ? PRIME1 : RUN;
    end

    // Previous phase: seeded on the last priming edge with the value s2 takes
    // on that same edge, so the first run cycle compares like with like
    always_ff @(posedge clk) begin
        if (reset)                 prev <= '0;
        else if (state == PRIME1)  prev <= {a_s1, b_s1};
        else if (state == RUN)     prev <= cur;
    end

    // Position count, direction, one-cycle pulses and saturating error total
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            up_down   <= 1'b1;
            step      <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            err  <= 1'b0;
            if (clear) begin
                count     <= '0;
                err_count <= '0;
            end else if (bad) begin
                err <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
            end else if (enable && (fwd || rev)) begin
                count   <= fwd ? count + 1'b1 : count - 1'b1;
                up_down <= fwd;
                step    <= 1'b1;
                wrap    <= fwd ? (count == '1) : (count == '0);
            end
        end
    end
endmodule

// File: tb/tb_quad_updown_decoder.sv
// tb_quad_updown_decoder: table-driven check of quadrature decoding, wrap, error saturation, enable, clear and reset
module tb_quad_updown_decoder;
    logic       clk = 1'b0;
    logic       reset, enable, clear, quad_a, quad_b;
    logic [3:0] count, err_count;
    logic       up_down, step, wrap, err;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic       a, b, en;
        logic [3:0] cnt;
        logic       ud, stp, wr, er;
        logic [3:0] ec;
    } vec_t;

    quad_updown_decoder #(.WIDTH(4), .ERR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .quad_a(quad_a), .quad_b(quad_b), .count(count), .up_down(up_down),
        .step(step), .wrap(wrap), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int a, b, en, cnt, ud, stp, wr, er, ec);
        vec_t v;
        v.a = a[0]; v.b = b[0]; v.en = en[0]; v.cnt = cnt[3:0];
        v.ud = ud[0]; v.stp = stp[0]; v.wr = wr[0]; v.er = er[0]; v.ec = ec[3:0];
        return v;
    endfunction

    // Drive one phase for 4 clocks; the decoded event must appear on exactly the 3rd edge
    task automatic apply_vec(input vec_t v, input string tag);
        quad_a = v.a; quad_b = v.b; enable = v.en;
        tick(); tick();
        chk({tag, " early step"}, 32'(step), 0);
        chk({tag, " early err"}, 32'(err), 0);
        tick();
        chk({tag, " count"}, 32'(count), 32'(v.cnt));
        chk({tag, " up_down"}, 32'(up_down), 32'(v.ud));
        chk({tag, " step"}, 32'(step), 32'(v.stp));
        chk({tag, " wrap"}, 32'(wrap), 32'(v.wr));
        chk({tag, " err"}, 32'(err), 32'(v.er));
        chk({tag, " err_count"}, 32'(err_count), 32'(v.ec));
        tick();
        chk({tag, " step drop"}, 32'(step), 0);
        chk({tag, " wrap drop"}, 32'(wrap), 0);
        chk({tag, " err drop"}, 32'(err), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " count"}, 32'(count), 0);
        chk({tag, " up_down"}, 32'(up_down), 1);
        chk({tag, " step"}, 32'(step), 0);
        chk({tag, " wrap"}, 32'(wrap), 0);
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " err_count"}, 32'(err_count), 0);
    endtask

    // Release reset and let priming finish while watching for spurious pulses
    task automatic release_and_prime(input string tag);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, " prime step"}, 32'(step), 0);
            chk({tag, " prime err"}, 32'(err), 0);
        end
        chk({tag, " prime count"}, 32'(count), 0);
    endtask

    task automatic do_reset(input logic a, input logic b, input string tag);
        reset = 1'b1; quad_a = a; quad_b = b;
        tick(); tick();
        chk_reset_vals(tag);
        release_and_prime(tag);
    endtask

    vec_t tbl [25];
    vec_t seq [10];

    initial begin
        reset = 1'b1; enable = 1'b1; clear = 1'b0; quad_a = 1'b1; quad_b = 1'b1;

        tbl[0]  = mk(1,0,1,  1,1,1,0,0,0);
        tbl[1]  = mk(1,1,1,  2,1,1,0,0,0);
        tbl[2]  = mk(0,1,1,  3,1,1,0,0,0);
        tbl[3]  = mk(0,0,1,  4,1,1,0,0,0);
        tbl[4]  = mk(0,1,1,  3,0,1,0,0,0);
        tbl[5]  = mk(1,1,1,  2,0,1,0,0,0);
        tbl[6]  = mk(1,0,1,  1,0,1,0,0,0);
        tbl[7]  = mk(0,0,1,  0,0,1,0,0,0);
        tbl[8]  = mk(0,1,1, 15,0,1,1,0,0);
        tbl[9]  = mk(1,1,1, 14,0,1,0,0,0);
        tbl[10] = mk(1,0,1, 13,0,1,0,0,0);
        tbl[11] = mk(0,0,1, 12,0,1,0,0,0);
        tbl[12] = mk(1,1,1, 12,0,0,0,1,1);
        tbl[13] = mk(1,0,1, 11,0,1,0,0,1);
        tbl[14] = mk(0,1,1, 11,0,0,0,1,2);
        tbl[15] = mk(0,0,0, 11,0,0,0,0,2);
        tbl[16] = mk(1,0,0, 11,0,0,0,0,2);
        tbl[17] = mk(1,1,0, 11,0,0,0,0,2);
        tbl[18] = mk(0,1,1, 12,1,1,0,0,2);
        tbl[19] = mk(0,0,1, 13,1,1,0,0,2);
        tbl[20] = mk(1,0,1, 14,1,1,0,0,2);
        tbl[21] = mk(1,1,1, 15,1,1,0,0,2);
        tbl[22] = mk(0,1,1,  0,1,1,1,0,2);
        tbl[23] = mk(1,0,0,  0,1,0,0,1,3);
        tbl[24] = mk(0,1,1,  0,1,0,0,1,4);

        seq[0] = mk(1,1,1, 0,1,0,0,1,1);
        seq[1] = mk(0,0,1, 0,1,0,0,1,2);
        seq[2] = mk(1,1,1, 0,1,0,0,1,3);
        seq[3] = mk(0,1,1, 1,1,1,0,0,3);
        seq[4] = mk(0,0,1, 2,1,1,0,0,3);
        seq[5] = mk(1,0,1, 3,1,1,0,0,3);
        seq[6] = mk(1,1,1, 4,1,1,0,0,3);
        seq[7] = mk(0,1,1, 5,1,1,0,0,3);
        seq[8] = mk(0,0,1, 6,1,1,0,0,3);
        seq[9] = mk(1,0,1, 7,1,1,0,0,3);

        do_reset(1'b1, 1'b1, "reset11");
        chk("reset11 up_down after prime", 32'(up_down), 1);

        do_reset(1'b0, 1'b0, "reset00");
        for (int i = 0; i < 25; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 20; i++)
            apply_vec(mk(i % 2 == 0 ? 1 : 0, i % 2 == 0 ? 0 : 1, 1, 0, 1, 0, 0, 1,
                         (5 + i > 15) ? 15 : 5 + i), $sformatf("sat%0d", i));

        do_reset(1'b0, 1'b0, "reset_clr");
        for (int i = 0; i < 10; i++) apply_vec(seq[i], $sformatf("seq%0d", i));

        quad_a = 1'b1; quad_b = 1'b1;
        tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear count", 32'(count), 0);
        chk("clear err_count", 32'(err_count), 0);
        chk("clear step", 32'(step), 0);
        chk("clear wrap", 32'(wrap), 0);
        chk("clear err", 32'(err), 0);
        chk("clear up_down", 32'(up_down), 1);
        tick();
        chk("post clear step", 32'(step), 0);
        chk("post clear count", 32'(count), 0);
        apply_vec(mk(0,1,1, 1,1,1,0,0,0), "after clear up");
        apply_vec(mk(1,1,1, 0,0,1,0,0,0), "after clear down");

        quad_a = 1'b1; quad_b = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk_reset_vals("mid reset");
        release_and_prime("mid reset");
        apply_vec(mk(0,0,1, 15,0,1,1,0,0), "after reset down");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/quad_updown_decoder.md
Name: quad_updown_decoder

Overview:
- Receive-side partner of the up/down counter family: decodes a two-phase quadrature pair (quad_a, quad_b) into step/direction events and keeps a wrapping position count.
- Drives the same enable/up_down/count semantics the counters consume, so a downstream counter or display sees a decoded direction instead of a host-driven one.
- Contains input synchronisers, a prime/run state machine, a transition decoder, the position counter and a saturating error counter.

Parameters:
- WIDTH, 4, width of position count.
- ERR_WIDTH, 4, width of saturating illegal-transition counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = decoded steps update count; 0 = hold count.
- clear  input  1  synchronous clear of count and err_count.
- quad_a  input  1  phase A, asynchronous to clk.
- quad_b  input  1  phase B, asynchronous to clk.
- count  output  WIDTH  position count.
- up_down  output  1  last decoded direction: 1 = up, 0 = down.
- step  output  1  one-cycle pulse on each counted step.
- wrap  output  1  one-cycle pulse when count wraps (max->0 or 0->max).
- err  output  1  one-cycle pulse on an illegal transition.
- err_count  output  ERR_WIDTH  saturating illegal-transition total.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset (sampled on a rising edge with reset=1): count=0, up_down=1, step=0, wrap=0, err=0, err_count=0, synchronisers=00, FSM=PRIME.
- Synchroniser: quad_a/quad_b each pass through 2 flops (s1, s2). Only the s2 values are decoded.
- FSM PRIME: runs 2 cycles after reset release. On the 2nd cycle it loads prev={a_s2,b_s2} with no decode, then enters RUN. This avoids a spurious step or error from the reset value.
- FSM RUN: every cycle compares cur={a_s2,b_s2} against prev, then loads prev=cur.
- Up transitions (A leads): 00->10, 10->11, 11->01, 01->00.
- Down transitions: 00->01, 01->11, 11->10, 10->00.
- cur==prev: no event.
- Both bits changed (00<->11, 01<->10): illegal. err=1 for one cycle; err_count increments and saturates at 2^ERR_WIDTH-1; count and up_down unchanged.
- Valid step with enable=1: count +/-1 modulo 2^WIDTH, up_down updated to the step direction, step=1 for one cycle. wrap=1 in the same cycle when count goes 2^WIDTH-1 -> 0 (up) or 0 -> 2^WIDTH-1 (down).
- enable=0:
  - prev still tracks the inputs.
  - count, up_down and step are held or suppressed.
  - err and err_count remain active.
- Latency: an input edge set up before rising edge N is in s1 at N, in s2 at N+1, and updates count/step/err at N+2.
- Precedence:
  - reset beats clear.
  - clear beats any step or error in the same cycle.
  - clear forces count=0 and err_count=0, and drops that cycle's step/wrap/err pulses.
  - clear does not change up_down or prev.
- Reset mid-operation returns to PRIME. Input history is discarded.
- All outputs are registered. step, wrap and err are never high for two consecutive cycles unless consecutive events occur.
- Inputs changing faster than one state per clk can alias into illegal transitions. That is flagged by err, not corrected.

Test Plan:
- Reset with quad inputs held at 11, release, wait 4 cycles -> count=0, step=0, err=0, up_down=1 (no spurious event from priming).
- enable=1, drive an up sequence 00,10,11,01,00 with 4 clk per phase -> count 0->4; 4 step pulses each 3 edges after its input edge; up_down=1.
- From count=2, drive 6 down steps -> count 2,1,0,15,14,13,12; wrap pulses exactly once on 0->15; up_down=0.
- Jump 00->11, then 10->01 -> err pulses twice, err_count=2, count unchanged. Drive 20 illegal jumps -> err_count saturates at 15.
- enable=0 during 3 up steps, then enable=1 and 1 up step -> count increments by 1 only, with no step pulses while disabled.
- Assert clear in the same cycle a step decodes with count=7 and err_count=3 -> count=0, err_count=0, no step pulse. Then assert reset mid-sequence -> all outputs at reset values next cycle.
